// File: rtl/mips_pkg.sv
// Shared definitions for the fetch/decode front end: NOP encoding, default
// widths and the queued fetch entry layout.
package mips_pkg;

  localparam int unsigned INSTR_W_DEF = 32;
  localparam int unsigned PC_W_DEF    = 32;
  localparam int unsigned FQ_DEPTH_DEF = 4;

  localparam logic [INSTR_W_DEF-1:0] NOP_INSTR = 32'h0000_0000;

  typedef struct packed {
    logic [INSTR_W_DEF-1:0] instr;
    logic [PC_W_DEF-1:0]    pc4;
  } fq_entry_t;

endpackage

// File: rtl/fetch_queue_mem.sv
// DEPTH x DW register array: one synchronous write port, one asynchronous
// read port, no reset (contents are don't-care until written).
module fetch_queue_mem #(
  parameter int unsigned DW    = 64,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned PW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [PW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch queue between instruction memory and decode; presents a
// NOP bubble to decode while empty and flushes in one cycle on a redirect.
module fetch_queue
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = INSTR_W_DEF,
  parameter int unsigned AW    = PC_W_DEF,
  parameter int unsigned DEPTH = FQ_DEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  output logic                     push_ready,
  input  logic [WIDTH-1:0]         push_instr,
  input  logic [AW-1:0]            push_pc4,
  input  logic                     pop_ready,
  output logic                     pop_valid,
  output logic [WIDTH-1:0]         pop_instr,
  output logic [AW-1:0]            pop_pc4,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam int unsigned DW = WIDTH + AW;

  logic [PW-1:0] wp_q, wp_d;
  logic [PW-1:0] rp_q, rp_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_fire, pop_fire, mem_we;
  logic [DW-1:0] rd_data;

  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);
  assign push_ready = !full;
  assign pop_valid  = !empty;
  assign count      = count_q;

  assign push_fire = push_valid && push_ready;
  assign pop_fire  = pop_ready && pop_valid;
  // A push coinciding with flush or reset is discarded, so skip the write too.
  assign mem_we    = push_fire && !flush && !reset;

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    count_d = count_q;
    if (flush) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_fire) wp_d = wp_q + PW'(1);
      if (pop_fire)  rp_d = rp_q + PW'(1);
      if (push_fire && !pop_fire)      count_d = count_q + CW'(1);
      else if (pop_fire && !push_fire) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q    <= '0;
      rp_q    <= '0;
      count_q <= '0;
    end else begin
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      count_q <= count_d;
    end
  end

  fetch_queue_mem #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .PW    (PW)
  ) u_mem (
    .clk   (clk),
    .we    (mem_we),
    .waddr (wp_q),
    .wdata ({push_instr, push_pc4}),
    .raddr (rp_q),
    .rdata (rd_data)
  );

  assign pop_instr = empty ? WIDTH'(NOP_INSTR) : rd_data[DW-1:AW];
  assign pop_pc4   = empty ? '0 : rd_data[AW-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=4) with hand-computed expectations.
module tb_fetch_queue;
  import mips_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        push_valid = 1'b0;
  logic        push_ready;
  logic [31:0] push_instr = '0;
  logic [31:0] push_pc4 = '0;
  logic        pop_ready = 1'b0;
  logic        pop_valid;
  logic [31:0] pop_instr;
  logic [31:0] pop_pc4;
  logic        flush = 1'b0;
  logic [2:0]  count;
  logic        full;
  logic        empty;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  fetch_queue #(
    .WIDTH (32),
    .AW    (32),
    .DEPTH (DEPTH)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .push_valid (push_valid),
    .push_ready (push_ready),
    .push_instr (push_instr),
    .push_pc4   (push_pc4),
    .pop_ready  (pop_ready),
    .pop_valid  (pop_valid),
    .pop_instr  (pop_instr),
    .pop_pc4    (pop_pc4),
    .flush      (flush),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_push(input fq_entry_t e);
    push_valid = 1'b1;
    push_instr = e.instr;
    push_pc4   = e.pc4;
  endtask

  task automatic check_idle(input string tag);
    check_val({tag, ".push_ready"}, 64'(push_ready), 64'd1);
    check_val({tag, ".pop_valid"},  64'(pop_valid),  64'd0);
    check_val({tag, ".pop_instr"},  64'(pop_instr),  64'd0);
    check_val({tag, ".pop_pc4"},    64'(pop_pc4),    64'd0);
    check_val({tag, ".count"},      64'(count),      64'd0);
    check_val({tag, ".empty"},      64'(empty),      64'd1);
    check_val({tag, ".full"},       64'(full),       64'd0);
  endtask

  task automatic check_head(input string tag, input logic [31:0] ins, input logic [31:0] pc);
    check_val({tag, ".pop_valid"}, 64'(pop_valid), 64'd1);
    check_val({tag, ".pop_instr"}, 64'(pop_instr), 64'(ins));
    check_val({tag, ".pop_pc4"},   64'(pop_pc4),   64'(pc));
  endtask

  initial begin
    #1;
    // Reset state
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle("rst");

    // Single push, no bypass into the head in the same cycle
    drive_push('{instr: 32'h2008_0005, pc4: 32'h4});
    #1;
    check_val("nobypass.pop_valid", 64'(pop_valid), 64'd0);
    tick();
    push_valid = 1'b0;
    check_head("push1", 32'h2008_0005, 32'h4);
    check_val("push1.count", 64'(count), 64'd1);

    flush = 1'b1;
    tick();
    flush = 1'b0;
    check_idle("flush1");

    // Fill to DEPTH, then try an extra push
    for (int unsigned i = 0; i < DEPTH; i++) begin
      drive_push('{instr: 32'hA000_0000 + i, pc4: 32'h10 + 4 * i});
      tick();
      check_val($sformatf("fill%0d.count", i), 64'(count), 64'(i + 1));
    end
    check_val("fill.full", 64'(full), 64'd1);
    check_val("fill.push_ready", 64'(push_ready), 64'd0);
    drive_push('{instr: 32'hDEAD_BEEF, pc4: 32'hFC});
    tick();
    push_valid = 1'b0;
    check_val("overflow.count", 64'(count), 64'd4);
    check_head("overflow.head", 32'hA000_0000, 32'h10);

    pop_ready = 1'b1;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      check_head($sformatf("drain%0d", i), 32'hA000_0000 + i, 32'h10 + 4 * i);
      tick();
    end
    check_val("drain.empty", 64'(empty), 64'd1);
    check_val("drain.pop_instr", 64'(pop_instr), 64'd0);
    check_val("drain.pop_valid", 64'(pop_valid), 64'd0);
    // Pop while empty has no effect
    tick();
    check_val("emptypop.count", 64'(count), 64'd0);
    pop_ready = 1'b0;

    // Steady-state push+pop, pointers wrap several times
    drive_push('{instr: 32'hB000_0000, pc4: 32'h100});
    tick();
    check_val("stream.prime.count", 64'(count), 64'd1);
    pop_ready = 1'b1;
    for (int unsigned i = 0; i < 10; i++) begin
      drive_push('{instr: 32'hB000_0001 + i, pc4: 32'h104 + 4 * i});
      check_head($sformatf("stream%0d", i), 32'hB000_0000 + i, 32'h100 + 4 * i);
      tick();
      check_val($sformatf("stream%0d.count", i), 64'(count), 64'd1);
    end
    push_valid = 1'b0;
    check_head("stream.last", 32'hB000_000A, 32'h128);
    tick();
    pop_ready = 1'b0;
    check_val("stream.empty", 64'(empty), 64'd1);

    // Flush with count=3 while push and pop are also requested
    for (int unsigned i = 0; i < 3; i++) begin
      drive_push('{instr: 32'hC000_0000 + i, pc4: 32'h200 + 4 * i});
      tick();
    end
    check_val("pre_flush.count", 64'(count), 64'd3);
    drive_push('{instr: 32'hC0DE_0000, pc4: 32'h2FC});
    pop_ready = 1'b1;
    flush = 1'b1;
    tick();
    check_idle("flush3");
    // Held flush keeps the queue empty despite pushes
    tick();
    check_idle("flush_hold");
    flush = 1'b0;
    pop_ready = 1'b0;
    drive_push('{instr: 32'hC111_1111, pc4: 32'h300});
    tick();
    push_valid = 1'b0;
    check_head("post_flush", 32'hC111_1111, 32'h300);
    check_val("post_flush.count", 64'(count), 64'd1);

    // Reset while full with flush asserted
    for (int unsigned i = 0; i < 3; i++) begin
      drive_push('{instr: 32'hE000_0000 + i, pc4: 32'h400 + 4 * i});
      tick();
    end
    push_valid = 1'b0;
    check_val("pre_reset.full", 64'(full), 64'd1);
    reset = 1'b1;
    flush = 1'b1;
    tick();
    reset = 1'b0;
    flush = 1'b0;
    check_idle("rst_full");
    drive_push('{instr: 32'hF00D_CAFE, pc4: 32'h500});
    tick();
    push_valid = 1'b0;
    check_head("post_rst", 32'hF00D_CAFE, 32'h500);
    check_val("post_rst.count", 64'(count), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction fetch queue that replaces the single fetch-to-decode pipeline register with a DEPTH-entry FIFO between instruction memory and the decode stage. Fetch pushes {instruction, PC+4} pairs while space remains. Decode pops one pair per cycle unless it is stalled. A branch, jump or jr redirect flushes every queued entry in one cycle. When the queue is empty, decode sees a NOP bubble, so the queue absorbs decode stalls without freezing the fetch PC.

## Interface
Parameters:
- `WIDTH`, default 32: instruction width in bits.
- `AW`, default 32: PC+4 width in bits.
- `DEPTH`, default 4: number of entries. Must be a power of two and ≥ 2.

Ports (clock and reset first):
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high. Sampled on the rising edge of `clk`.
- `push_valid`  in  1  fetch offers an entry this cycle.
- `push_ready`  out  1  queue can accept an entry; equals `!full`.
- `push_instr`  in  WIDTH  fetched instruction.
- `push_pc4`  in  AW  PC+4 of the fetched instruction.
- `pop_ready`  in  1  decode consumes the head entry; driven as `!StallD`.
- `pop_valid`  out  1  head entry is valid; equals `!empty`.
- `pop_instr`  out  WIDTH  head instruction; `0` (NOP) when empty.
- `pop_pc4`  out  AW  head PC+4; `0` when empty.
- `flush`  in  1  redirect (PCSrcD, Jump or Jr); discards all entries.
- `count`  out  $clog2(DEPTH)+1  number of valid entries.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.

## Operation
- Transfer rules:
  - Push is accepted when `push_valid && push_ready`.
  - Pop happens when `pop_ready && pop_valid`.
  - `pop_ready` while empty has no effect.
- Storage and pointers:
  - Circular buffer with write pointer `wp` and read pointer `rp`, each `$clog2(DEPTH)` bits.
  - Both pointers wrap modulo DEPTH by natural overflow.
  - `count` is held as a separate register. It is not derived from the pointers.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop together: unchanged. Both pointers advance. This is legal when non-empty and non-full.
  - When full, `push_ready=0`, so no push occurs. A pop when full still happens.
- No write-through bypass: an entry pushed into an empty queue appears at the head on the next cycle.
- Flush: on the next edge, `count=0` and `wp=rp=0`. Any push or pop in the same cycle is discarded.
- Reset has priority over flush.
- Reset or flush mid-stream drops all pending entries. Storage contents are don't-care, but `pop_instr`/`pop_pc4` are forced to 0 while empty.
- Head outputs are a combinational read of `mem[rp]`, gated by `!empty`.

## Timing
- Values after reset or flush: `push_ready=1`, `pop_valid=0`, `pop_instr=0`, `pop_pc4=0`, `count=0`, `empty=1`, `full=0`.
- Latency from push to head is 1 cycle when the queue is empty. When non-empty, an entry reaches the head in FIFO order.
- Throughput is 1 push and 1 pop per cycle in steady state.
- Handshake outputs `push_ready`, `pop_valid`, `full`, `empty` and `count` are pure functions of registered state. None depend combinationally on `push_valid` or `pop_ready`, so there is no loop through the hazard unit.
- `flush` asserted for N consecutive cycles keeps the queue empty for those N cycles. The first push accepted after flush deasserts lands at entry 0.

## Structure
- Shared package `mips_pkg` holds:
  - `NOP_INSTR = 32'h0000_0000`.
  - Default widths.
  - The typedef `fq_entry_t = {instr, pc4}`.
- Sub-module `fetch_queue_mem` is the DEPTH×(WIDTH+AW) register array with one synchronous write port and one asynchronous read port, with no reset.
- The top level holds the pointers, `count` and flags.

## Test plan
- Reset, then push 0x20080005/PC4=0x4 with `pop_ready=0`.
  - Next cycle: `pop_valid=1`, `pop_instr=0x20080005`, `pop_pc4=0x4`, `count=1`.
- Push 4 distinct instructions with `pop_ready=0` (DEPTH=4).
  - After the 4th: `full=1`, `push_ready=0`.
  - A 5th push is ignored. Popping 4 returns the entries in order, after which `empty=1` and `pop_instr=0`.
- Continuous push and pop for 10 cycles with DEPTH=4.
  - `count` stays at 1 and output order matches input.
  - Pointers wrap past 3→0 without loss.
- With `count=3`, assert `flush` together with `push_valid` and `pop_ready`.
  - Next cycle: `count=0`, `pop_valid=0`, `pop_instr=0`, and the pushed entry is absent.
- Assert `reset` while full with `flush=1`.
  - Next cycle: all outputs at reset values.
  - A push on the following cycle appears at the head one cycle later.
